core_pipe_exec_mdu: RTL and testbench

CORE_PIPE_EXEC_MDU -- requirements
Module: core_pipe_exec_mdu

---
 rtl/core_pipe_exec_mdu.sv | 177 +++++++++++++++++
 tb/tb_core_pipe_exec_mdu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_exec_mdu.sv
// Iterative multiply/divide unit: shift-add multiplier, restoring divider, RV64 W-forms.
// Define CORE_MDU_DIV_EN to build the divider; without it div*/rem* complete at once with result 0.
module core_pipe_exec_mdu #(
    parameter int XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            valid,
    output logic            ready,
    input  logic            flush,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    input  logic            word,
    input  logic            op_mul,
    input  logic            op_mulh,
    input  logic            op_mulhsu,
    input  logic            op_mulhu,
    input  logic            op_div,
    input  logic            op_divu,
    input  logic            op_rem,
    input  logic            op_remu,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int         PW     = 2 * XLEN;
    localparam logic [5:0] K_FULL = 6'(XLEN);

`ifdef CORE_MDU_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        return XLEN'($signed(x[31:0]));
    endfunction

    function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] x, input logic w);
        return w ? sext32(x) : x;
    endfunction

    state_t          state;
    logic [5:0]      count;
    logic            r_word, r_high, r_neg;
    logic            is_mulh, is_mul, is_div, word_eff, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;
    logic [5:0]      k_steps;

    assign ready    = (state == IDLE);
    assign is_mulh  = op_mulh | op_mulhsu | op_mulhu;
    assign is_mul   = op_mul | is_mulh;
    assign is_div   = op_div | op_divu | op_rem | op_remu;
    assign word_eff = (XLEN == 64) && word && !is_mulh;
    assign a_signed = op_mulh | op_mulhsu | op_div | op_rem;
    assign b_signed = op_mulh | op_div | op_rem;
    assign a_ext    = !word_eff ? opr_a : (a_signed ? sext32(opr_a) : XLEN'(opr_a[31:0]));
    assign b_ext    = !word_eff ? opr_b : (b_signed ? sext32(opr_b) : XLEN'(opr_b[31:0]));
    assign a_neg    = a_signed & a_ext[XLEN-1];
    assign b_neg    = b_signed & b_ext[XLEN-1];
    assign mag_a    = a_neg ? -a_ext : a_ext;
    assign mag_b    = b_neg ? -b_ext : b_ext;
    assign k_steps  = word_eff ? 6'd32 : K_FULL;

    // Multiplier works on magnitudes; the final step's sum feeds the result directly.
    logic [PW-1:0]   m_acc, m_cand, m_acc_nxt, m_prod;
    logic [XLEN-1:0] m_plier, mul_res;

    assign m_acc_nxt = m_plier[0] ? m_acc + m_cand : m_acc;
    assign m_prod    = r_neg ? -m_acc_nxt : m_acc_nxt;
    assign mul_res   = r_high ? m_prod[PW-1:XLEN] : word_fix(m_prod[XLEN-1:0], r_word);

`ifdef CORE_MDU_DIV_EN
    logic [XLEN-1:0] d_rem, d_quo, d_dsr, d_rem_nxt, d_quo_nxt, d_q_fix, d_r_fix, div_res, div_special;
    logic [XLEN:0]   d_shift, d_diff;
    logic            r_rem, r_neg_r, div_zero, div_ovf, op_is_rem;

    assign d_shift   = {d_rem, d_quo[XLEN-1]};
    assign d_diff    = d_shift - {1'b0, d_dsr};
    assign d_rem_nxt = d_diff[XLEN] ? d_shift[XLEN-1:0] : d_diff[XLEN-1:0];
    assign d_quo_nxt = {d_quo[XLEN-2:0], !d_diff[XLEN]};
    assign d_q_fix   = r_neg ? -d_quo_nxt : d_quo_nxt;
    assign d_r_fix   = r_neg_r ? -d_rem_nxt : d_rem_nxt;
    assign div_res   = word_fix(r_rem ? d_r_fix : d_q_fix, r_word);

    // Divide-by-zero and most-negative/-1 bypass the iteration entirely.
    assign op_is_rem   = op_rem | op_remu;
    assign div_zero    = (b_ext == '0);
    assign div_ovf     = (op_div | op_rem) &&
                         (word_eff ? (opr_a[31:0] == 32'h8000_0000 && opr_b[31:0] == 32'hFFFF_FFFF)
                                   : (opr_a == {1'b1, {(XLEN-1){1'b0}}} && opr_b == '1));
    assign div_special = word_fix(div_zero ? (op_is_rem ? opr_a : '1)
                                           : (op_is_rem ? '0 : opr_a), word_eff);
`endif

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        r_word <= word_eff;
                        r_high <= is_mulh;
                        r_neg  <= a_neg ^ b_neg;
                        count  <= k_steps;
                        if (is_mul) begin
                            m_acc   <= '0;
                            m_cand  <= PW'(mag_a);
                            m_plier <= mag_b;
                            state   <= MUL;
                        end else if (is_div) begin
`ifdef CORE_MDU_DIV_EN
                            r_rem   <= op_is_rem;
                            r_neg_r <= a_neg;
                            d_rem   <= '0;
                            d_quo   <= word_eff ? (mag_a << (XLEN - 32)) : mag_a;
                            d_dsr   <= mag_b;
                            if (div_zero || div_ovf) begin
                                result    <= div_special;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                state <= DIV;
                            end
`else
                            result    <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
`endif
                        end
                    end
                end
                MUL: begin
                    m_acc   <= m_acc_nxt;
                    m_cand  <= m_cand << 1;
                    m_plier <= m_plier >> 1;
                    count   <= count - 6'd1;
                    if (count == 6'd1) begin
                        result    <= mul_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`ifdef CORE_MDU_DIV_EN
                DIV: begin
                    d_rem <= d_rem_nxt;
                    d_quo <= d_quo_nxt;
                    count <= count - 6'd1;
                    if (count == 6'd1) begin
                        result    <= div_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        result    <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_pipe_exec_mdu.sv
// Testbench for core_pipe_exec_mdu: directed vectors with a queue scoreboard checked by a monitor.
// Divide expectations follow CORE_MDU_DIV_EN as defined for the build.
module tb_core_pipe_exec_mdu;
    localparam int XLEN = 64;
    localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
    localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;
    localparam logic [XLEN-1:0] ONES = '1;

    logic            g_clk = 1'b0;
    logic            g_resetn, valid, ready, flush, word, out_valid, out_ready;
    logic [XLEN-1:0] opr_a, opr_b, result;
    logic [7:0]      op_vec;
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    bit              mon_en = 1'b0;
    logic [XLEN-1:0] sb_res[$];
    int              sb_due[$];
    string           sb_tag[$];

    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc <= cyc + 1;

    core_pipe_exec_mdu #(.XLEN(XLEN)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .ready(ready), .flush(flush),
        .opr_a(opr_a), .opr_b(opr_b), .word(word),
        .op_mul(op_vec[OP_MUL]), .op_mulh(op_vec[OP_MULH]), .op_mulhsu(op_vec[OP_MULHSU]),
        .op_mulhu(op_vec[OP_MULHU]), .op_div(op_vec[OP_DIV]), .op_divu(op_vec[OP_DIVU]),
        .op_rem(op_vec[OP_REM]), .op_remu(op_vec[OP_REMU]),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(negedge g_clk);
            n++;
        end
        checkOutput("ready wait", 64'(ready), 64'd1);
    endtask

    // Issue one request at a negedge; the accept happens on the following posedge.
    task automatic applyStimulus(input int op, input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input bit expect_out, input logic [XLEN-1:0] exp_res, input int lat,
                                 input string tag);
        waitReady();
        op_vec     = '0;
        op_vec[op] = 1'b1;
        word       = w;
        opr_a      = a;
        opr_b      = b;
        valid      = 1'b1;
        if (expect_out) begin
            sb_res.push_back(exp_res);
            sb_due.push_back(cyc + lat);
            sb_tag.push_back(tag);
        end
        @(negedge g_clk);
        valid  = 1'b0;
        op_vec = '0;
    endtask

    task automatic applyDiv(input int op, input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [XLEN-1:0] exp_res, input int lat, input string tag);
`ifdef CORE_MDU_DIV_EN
        applyStimulus(op, w, a, b, 1'b1, exp_res, lat, tag);
`else
        applyStimulus(op, w, a, b, 1'b1, (exp_res & '0), 1 + (lat & 0), tag);
`endif
    endtask

    initial begin : monitor
        logic  prev_ov;
        string t;
        prev_ov = 1'b0;
        forever begin
            @(negedge g_clk);
            if (mon_en) begin
                if (out_valid === 1'b1 && !prev_ov) begin
                    if (sb_res.size() == 0) begin
                        checkOutput("unexpected out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        t = sb_tag.pop_front();
                        checkOutput({t, " result"}, result, sb_res.pop_front());
                        checkOutput({t, " cycle"}, 64'(cyc), 64'(sb_due.pop_front()));
                    end
                end else if (out_valid !== 1'b1) begin
                    checkOutput("result zero without out_valid", result, '0);
                end
            end
            prev_ov = (out_valid === 1'b1);
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int n;
        g_resetn = 1'b0; valid = 1'b0; flush = 1'b0; word = 1'b0; out_ready = 1'b1;
        opr_a = '0; opr_b = '0; op_vec = '0;
        repeat (3) @(negedge g_clk);
        checkOutput("reset ready", 64'(ready), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset result", result, 64'd0);
        g_resetn = 1'b1;
        mon_en   = 1'b1;
        @(negedge g_clk);

        applyStimulus(OP_MUL, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul 7*-3");
        applyStimulus(OP_MULHU, 0, ONES, ONES, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu ones");
        applyStimulus(OP_MULH, 0, ONES, ONES, 1, 64'd0, 65, "mulh -1*-1");
        applyStimulus(OP_MULHSU, 0, ONES, ONES, 1, ONES, 65, "mulhsu -1*max");
        applyStimulus(OP_MULH, 0, 64'h4000_0000_0000_0000, 64'd4, 1, 64'd1, 65, "mulh 2^62*4");
        applyStimulus(OP_MUL, 1, 64'hAAAA_AAAA_7FFF_FFFF, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw");
        applyStimulus(OP_MULHU, 1, 64'h8000_0000_0000_0000, 64'd4, 1, 64'd2, 65, "mulhu word ignored");

        applyDiv(OP_DIV, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div -7/2");
        applyDiv(OP_REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, "rem -7/2");
        applyDiv(OP_DIV, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw -7/2");
        applyDiv(OP_REM, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 33, "remw -7/2");
        applyDiv(OP_DIV, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div 7/-2");
        applyDiv(OP_REM, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, "rem 7/-2");
        applyDiv(OP_DIVU, 0, 64'd100, 64'd7, 64'd14, 65, "divu 100/7");
        applyDiv(OP_REMU, 0, 64'd100, 64'd7, 64'd2, 65, "remu 100/7");
        applyDiv(OP_DIVU, 1, 64'h5555_5555_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, "divuw");
        applyDiv(OP_DIVU, 0, 64'h1234, 64'd0, ONES, 1, "divu by zero");
        applyDiv(OP_REMU, 0, 64'h1234, 64'd0, 64'h1234, 1, "remu by zero");
        applyDiv(OP_REM, 0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, "rem -5/0");
        applyDiv(OP_REM, 1, 64'h0000_0001_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1, "remw by zero");
        applyDiv(OP_DIV, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw ovf");
        applyDiv(OP_REM, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1, "remw ovf");
        applyDiv(OP_DIV, 0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1, "div ovf");
        applyDiv(OP_REM, 0, 64'h8000_0000_0000_0000, ONES, 64'd0, 1, "rem ovf");

        // Back-pressure: result must hold while the consumer stalls.
        waitReady();
        out_ready = 1'b0;
        applyStimulus(OP_MUL, 0, 64'd3, 64'd5, 1, 64'd15, 65, "mul hold");
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge g_clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold out_valid", 64'(out_valid), 64'd1);
            checkOutput("hold result", result, 64'd15);
            checkOutput("hold ready", 64'(ready), 64'd0);
            @(negedge g_clk);
        end
        out_ready = 1'b1;
        @(negedge g_clk);
        checkOutput("release ready", 64'(ready), 64'd1);
        checkOutput("release out_valid", 64'(out_valid), 64'd0);

        // A request presented together with flush must not be taken.
        waitReady();
        op_vec[OP_MUL] = 1'b1; opr_a = 64'd3; opr_b = 64'd5; word = 1'b0;
        valid = 1'b1; flush = 1'b1;
        @(negedge g_clk);
        valid = 1'b0; flush = 1'b0; op_vec = '0;
        checkOutput("flush blocks accept", 64'(ready), 64'd1);

        // Abort a long operation by flush, then by reset; no output may appear.
        for (int m = 0; m < 2; m++) begin
`ifdef CORE_MDU_DIV_EN
            applyStimulus(OP_DIV, 0, 64'd100, 64'd7, 0, '0, 0, "div aborted");
`else
            applyStimulus(OP_MUL, 0, 64'd100, 64'd7, 0, '0, 0, "mul aborted");
`endif
            repeat (9) @(negedge g_clk);
            if (m == 0) flush = 1'b1;
            else        g_resetn = 1'b0;
            @(negedge g_clk);
            flush    = 1'b0;
            g_resetn = 1'b1;
            checkOutput(m == 0 ? "flush ready" : "abort reset ready", 64'(ready), 64'd1);
            checkOutput(m == 0 ? "flush out_valid" : "abort reset out_valid", 64'(out_valid), 64'd0);
            repeat (80) @(negedge g_clk);
            applyStimulus(OP_MUL, 0, 64'd3, 64'd5, 1, 64'd15, 65, "mul after abort");
        end

        n = 0;
        while (sb_res.size() != 0 && n < 300) begin
            @(negedge g_clk);
            n++;
        end
        checkOutput("scoreboard drained", 64'(sb_res.size()), 64'd0);
        repeat (2) @(negedge g_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
